llc_request_frontend: RTL and testbench

- Ingress stage directly upstream of the LLC controller. Accepts raw trace commands (4-bit code plus 32-bit address) through a valid/ready handshake and buffers them in a small FIFO.
- Decodes each code into an LLC operation, splits the address into tag/index/offset, and presents the result to the controller through a second valid/ready handshake.
- Sequences clear-cache requests (code 8) and counts illegal codes.

---
 rtl/llc_request_frontend.sv | 163 ++++++++++++++++
 tb/tb_llc_request_frontend.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_request_frontend.sv
// LLC request front-end: trace command intake, decode, request FIFO
// and clear-cache sequencing ahead of the LLC controller.
module llc_request_frontend #(
  parameter int ADDR_BITS   = 32,
  parameter int TAG_BITS    = 12,
  parameter int INDEX_BITS  = 14,
  parameter int OFFSET_BITS = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_code,
  input  logic [ADDR_BITS-1:0]   cmd_addr,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [2:0]             req_op,
  output logic                   req_snoop,
  output logic [TAG_BITS-1:0]    req_tag,
  output logic [INDEX_BITS-1:0]  req_index,
  output logic [OFFSET_BITS-1:0] req_offset,
  output logic                   clear_req,
  input  logic                   clear_ack,
  output logic [CNT_BITS-1:0]    illegal_cnt,
  output logic                   busy
);

  localparam int PW = $clog2(FIFO_DEPTH);

  if (TAG_BITS + INDEX_BITS + OFFSET_BITS != ADDR_BITS) begin : g_chk
    $fatal(1, "tag/index/offset widths do not sum to ADDR_BITS");
  end

  typedef struct packed {
    logic [2:0]             op;
    logic                   snoop;
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] offset;
  } ent_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_CLEAR,
    S_WAIT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  ent_t               r_mem [FIFO_DEPTH];
  logic [PW:0]        r_wptr;
  logic [PW:0]        r_rptr;
  logic [CNT_BITS-1:0] r_illegal_cnt;

  logic       w_empty;
  logic       w_full;
  logic       w_acc;
  logic       w_push;
  logic       w_pop;
  logic       w_legal;
  logic       w_is_clr;
  logic       w_illegal;
  logic [2:0] w_op;
  ent_t       w_ent;
  ent_t       w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW-1:0] == r_rptr[PW-1:0]) &&
                   (r_wptr[PW] != r_rptr[PW]);

  // Ready depends on registered state only; a same-cycle pop frees nothing.
  assign cmd_ready = (r_state == S_RUN) && !w_full;
  assign w_acc     = cmd_valid && cmd_ready;

  always_comb begin
    w_op      = '0;
    w_legal   = 1'b0;
    w_is_clr  = 1'b0;
    w_illegal = 1'b0;
    unique case (1'b1)
      (cmd_code <= 4'd6): begin
        w_op    = cmd_code[2:0];
        w_legal = 1'b1;
      end
      (cmd_code == 4'd9): begin
        w_op    = 3'd7;
        w_legal = 1'b1;
      end
      (cmd_code == 4'd8): w_is_clr = 1'b1;
      default:            w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_ent.op     = w_op;
    w_ent.snoop  = (w_op >= 3'd3) && (w_op <= 3'd6);
    w_ent.tag    = cmd_addr[ADDR_BITS-1 -: TAG_BITS];
    w_ent.index  = cmd_addr[INDEX_BITS+OFFSET_BITS-1 -: INDEX_BITS];
    w_ent.offset = cmd_addr[OFFSET_BITS-1:0];
  end

  assign w_push = w_acc && w_legal;
  assign w_pop  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr[PW-1:0]] <= w_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_acc && w_illegal && (r_illegal_cnt != '1)) begin
      r_illegal_cnt <= r_illegal_cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN:   if (w_acc && w_is_clr) w_next = S_DRAIN;
      S_DRAIN: if (w_empty)           w_next = S_CLEAR;
      S_CLEAR:                        w_next = S_WAIT;
      S_WAIT:  if (clear_ack)         w_next = S_RUN;
      default:                        w_next = S_RUN;
    endcase
  end

  assign w_head      = r_mem[r_rptr[PW-1:0]];
  assign req_valid   = !w_empty;
  assign req_op      = w_head.op;
  assign req_snoop   = w_head.snoop;
  assign req_tag     = w_head.tag;
  assign req_index   = w_head.index;
  assign req_offset  = w_head.offset;
  assign clear_req   = (r_state == S_CLEAR);
  assign busy        = (r_state != S_RUN);
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_llc_request_frontend.sv
// Bench for llc_request_frontend: directed and random commands,
// scoreboard monitor against a queue-based reference model.
module tb_llc_request_frontend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_code;
  logic [31:0] cmd_addr;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_snoop;
  logic [11:0] req_tag;
  logic [13:0] req_index;
  logic [5:0]  req_offset;
  logic        clear_req;
  logic        clear_ack;
  logic [15:0] illegal_cnt;
  logic        busy;

  llc_request_frontend dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_addr(cmd_addr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_snoop(req_snoop),
    .req_tag(req_tag), .req_index(req_index),
    .req_offset(req_offset),
    .clear_req(clear_req), .clear_ack(clear_ack),
    .illegal_cnt(illegal_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        sn;
    logic [11:0] tag;
    logic [13:0] idx;
    logic [5:0]  off;
  } exp_t;

  localparam int P_RUN = 0, P_DRAIN = 1, P_CLEAR = 2, P_WAIT = 3;
  localparam int DEPTH = 4;

  exp_t        q[$];
  int          ph = P_RUN;
  logic [15:0] m_cnt = '0;
  int          vecs = 0;
  int          fails = 0;
  bit          rnd = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t", n, act, exp, $time);
    end
  endtask

  // Reference: fields are plain arithmetic on the address.
  function automatic exp_t mk(input logic [3:0] c, input logic [31:0] a);
    exp_t e;
    e.op  = (c == 4'd9) ? 3'd7 : c[2:0];
    e.sn  = (c >= 4'd3) && (c <= 4'd6);
    e.tag = 12'(a / 32'h100000);
    e.idx = 14'((a / 64) % 16384);
    e.off = 6'(a % 64);
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        ph    = P_RUN;
        m_cnt = '0;
      end else begin
        bit acc;
        bit pop;
        chk("cmd_ready", cmd_ready, (ph == P_RUN) && (q.size() < DEPTH));
        chk("req_valid", req_valid, q.size() != 0);
        chk("clear_req", clear_req, ph == P_CLEAR);
        chk("busy", busy, ph != P_RUN);
        chk("illegal_cnt", illegal_cnt, m_cnt);
        if (q.size() != 0) begin
          chk("req_op", req_op, q[0].op);
          chk("req_snoop", req_snoop, q[0].sn);
          chk("req_tag", req_tag, q[0].tag);
          chk("req_index", req_index, q[0].idx);
          chk("req_offset", req_offset, q[0].off);
        end
        acc = cmd_valid && (ph == P_RUN) && (q.size() < DEPTH);
        pop = (q.size() != 0) && req_ready;
        case (ph)
          P_RUN:   if (acc && cmd_code == 4'd8) ph = P_DRAIN;
          P_DRAIN: if (q.size() == 0) ph = P_CLEAR;
          P_CLEAR: ph = P_WAIT;
          default: if (clear_ack) ph = P_RUN;
        endcase
        if (pop) void'(q.pop_front());
        if (acc) begin
          if (cmd_code <= 4'd6 || cmd_code == 4'd9)
            q.push_back(mk(cmd_code, cmd_addr));
          else if (cmd_code != 4'd8 && m_cnt != 16'hFFFF)
            m_cnt = m_cnt + 16'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a);
    bit done = 0;
    cmd_valid = 1'b1;
    cmd_code  = c;
    cmd_addr  = a;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = cmd_ready;
      tick();
      if (rnd && !done) begin
        req_ready = ($urandom % 3) != 0;
        clear_ack = ($urandom % 8) == 0;
      end
    end
    cmd_valid = 1'b0;
    clear_ack = 1'b0;
    if (!done) begin
      vecs++;
      fails++;
      $display("FAIL send_timeout: code %0d never accepted", c);
    end
  endtask

  task automatic wait_clear(input int ack_dly, input bit do_ack);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = clear_req;
    end
    vecs++;
    if (!seen) begin
      fails++;
      $display("FAIL clear_timeout: clear_req 0 required 1");
    end
    tick();
    if (do_ack) begin
      repeat (ack_dly - 1) tick();
      clear_ack = 1'b1;
      tick();
      clear_ack = 1'b0;
    end
  endtask

  task automatic reset_now(input string n);
    rst_n = 1'b0;
    #1;
    chk({n, "_req_valid"}, req_valid, 1'b0);
    chk({n, "_busy"}, busy, 1'b0);
    chk({n, "_clear_req"}, clear_req, 1'b0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = '0;
    cmd_addr  = '0;
    req_ready = 1'b0;
    clear_ack = 1'b0;
    repeat (2) tick();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_clear_req", clear_req, 1'b0);
    chk("rst_cnt", illegal_cnt, 16'h0);
    chk("rst_fields", {req_op, req_snoop, req_tag, req_index, req_offset},
        32'h0);
    rst_n = 1'b1;
    tick();

    req_ready = 1'b1;
    send(4'd0, 32'h12345678);
    chk("t1_valid", req_valid, 1'b1);
    chk("t1_op", req_op, 3'd0);
    chk("t1_snoop", req_snoop, 1'b0);
    chk("t1_tag", req_tag, 12'h123);
    chk("t1_index", req_index, 14'h1159);
    chk("t1_offset", req_offset, 6'h38);
    tick();

    req_ready = 1'b0;
    for (int c = 1; c <= 4; c++) send(4'(c), $urandom);
    fork
      send(4'd5, $urandom);
      begin
        repeat (3) tick();
        req_ready = 1'b1;
      end
    join
    repeat (6) tick();

    send(4'd7, $urandom);
    send(4'd12, $urandom);
    send(4'd15, $urandom);
    tick();
    chk("ill_cnt3", illegal_cnt, 16'd3);
    force dut.r_illegal_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    tick();
    release dut.r_illegal_cnt;
    send(4'd10, $urandom);
    send(4'd11, $urandom);
    send(4'd13, $urandom);
    tick();
    chk("ill_sat", illegal_cnt, 16'hFFFF);

    req_ready = 1'b0;
    send(4'd0, $urandom);
    send(4'd6, $urandom);
    send(4'd8, $urandom);
    repeat (2) tick();
    req_ready = 1'b1;
    wait_clear(3, 1'b1);
    tick();

    send(4'd9, 32'h0);
    send(4'd6, $urandom);
    send(4'd8, $urandom);
    wait_clear(2, 1'b1);
    tick();

    req_ready = 1'b0;
    send(4'd1, $urandom);
    send(4'd2, $urandom);
    send(4'd8, $urandom);
    req_ready = 1'b1;
    wait_clear(1, 1'b0);
    tick();
    reset_now("wait_rst");
    repeat (5) tick();

    req_ready = 1'b0;
    send(4'd3, $urandom);
    send(4'd4, $urandom);
    send(4'd8, $urandom);
    reset_now("drain_rst");
    repeat (5) tick();

    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] c;
      c = 4'($urandom % 16);
      req_ready = ($urandom % 3) != 0;
      send(c, $urandom);
      if (c == 4'd8) begin
        req_ready = 1'b1;
        wait_clear(1 + int'($urandom % 3), 1'b1);
      end
    end
    req_ready = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
